// File: rtl/mux_8x1_rr_arbiter.sv
// Round-robin packet arbiter driving select/en of the 8-input mux; a grant is held until the owner's last beat is accepted.
// Optional idle-grant watchdog enabled by defining MUX_ARB_TIMEOUT_EN.
module mux_8x1_rr_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] last,
    input  logic       out_ready,
    output logic [7:0] grant,
    output logic [2:0] select,
    output logic       en,
    output logic       out_valid,
    output logic       timeout
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t     state, state_nxt;
    logic [2:0] ptr, ptr_nxt;
    logic [2:0] pick, select_nxt;
    logic [7:0] grant_nxt;
    logic       en_nxt;
    logic       pick_vld;
    logic       accept;
    logic       release_pkt;
    logic       force_rel;

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("mux_8x1_rr_arbiter: TIMEOUT must be >= 2");
    end

    // Descending scan so the requester closest to ptr is the final (winning) assignment.
    always_comb begin
        pick     = ptr;
        pick_vld = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            if (req[ptr + 3'(k)]) begin
                pick     = ptr + 3'(k);
                pick_vld = 1'b1;
            end
        end
    end

    assign accept      = (state == BUSY) && req[select] && out_ready;
    assign release_pkt = (accept && last[select]) || force_rel;
    assign out_valid   = en & req[select];

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT + 1);

    logic [WDOG_W-1:0] wdog;

    assign force_rel = (state == BUSY) && !req[select] && (wdog == WDOG_W'(TIMEOUT - 1));

    // wdog counts consecutive starved cycles of the current owner; it is already 0 on entry to BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog    <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= force_rel;
            if (state != BUSY || req[select] || force_rel)
                wdog <= '0;
            else
                wdog <= wdog + 1'b1;
        end
    end
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= 3'd0;
            grant  <= 8'd0;
            select <= 3'd0;
            en     <= 1'b0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            grant  <= grant_nxt;
            select <= select_nxt;
            en     <= en_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = BUSY;
            BUSY:    if (release_pkt) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // select is left untouched on release so the mux index stays stable while en is low.
    always_comb begin
        grant_nxt  = grant;
        select_nxt = select;
        en_nxt     = en;
        ptr_nxt    = ptr;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    select_nxt = pick;
                    grant_nxt  = 8'd1 << pick;
                    en_nxt     = 1'b1;
                end
            end
            BUSY: begin
                if (release_pkt) begin
                    grant_nxt = 8'd0;
                    en_nxt    = 1'b0;
                    ptr_nxt   = select + 3'd1;
                end
            end
            default: begin
                grant_nxt = 8'd0;
                en_nxt    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mux_8x1_rr_arbiter.sv
// Directed bench for mux_8x1_rr_arbiter: an owner/pointer model checked every cycle plus literal expectations.
module tb_mux_8x1_rr_arbiter;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] req = 8'd0;
    logic [7:0] last = 8'd0;
    logic       out_ready = 1'b0;
    logic [7:0] grant;
    logic [2:0] select;
    logic       en;
    logic       out_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    mux_8x1_rr_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .last      (last),
        .out_ready (out_ready),
        .grant     (grant),
        .select    (select),
        .en        (en),
        .out_valid (out_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: owner index (-1 when nobody holds the mux), round-robin start point, starvation count.
    int   m_owner = -1;
    int   m_ptr   = 0;
    int   m_sel   = 0;
    int   m_idle  = 0;
    logic m_to    = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = 0;
            m_sel   = 0;
            m_idle  = 0;
            m_to    = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_owner < 0) begin
                for (int k = 0; k < 8; k++) begin
                    if (m_owner < 0 && req[(m_ptr + k) % 8]) m_owner = (m_ptr + k) % 8;
                end
                if (m_owner >= 0) begin
                    m_sel  = m_owner;
                    m_idle = 0;
                end
            end else begin
                bit done;
                done = req[m_owner] && out_ready && last[m_owner];
`ifdef MUX_ARB_TIMEOUT_EN
                if (!done) begin
                    if (req[m_owner]) m_idle = 0;
                    else if (m_idle == TIMEOUT - 1) begin
                        done = 1'b1;
                        m_to = 1'b1;
                    end else m_idle++;
                end
`endif
                if (done) begin
                    m_ptr   = (m_owner + 1) % 8;
                    m_owner = -1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] e_grant;
        e_grant = (m_owner < 0) ? 8'd0 : (8'd1 << m_owner);
        chk("grant", grant, e_grant);
        chk("en", {7'd0, en}, {7'd0, m_owner >= 0});
        chk("select", {5'd0, select}, 8'(m_sel));
        chk("out_valid", {7'd0, out_valid}, {7'd0, (m_owner >= 0) && req[m_sel]});
        chk("timeout", {7'd0, timeout}, {7'd0, m_to});
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL time_limit: simulation did not complete, got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        // reset held with every source requesting
        rst_n = 1'b0;
        req = 8'hFF;
        repeat (3) step();
        #1;
        chk("rst_grant", grant, 8'h00);
        chk("rst_en", {7'd0, en}, 8'h00);
        chk("rst_sel", {5'd0, select}, 8'h00);
        chk("rst_ovalid", {7'd0, out_valid}, 8'h00);
        req = 8'h00;
        step();
        rst_n = 1'b1;
        step();

        // single source, two-beat packet
        req = 8'h08; out_ready = 1'b1;
        step();
        chk("t2_sel", {5'd0, select}, 8'd3);
        chk("t2_grant", grant, 8'h08);
        chk("t2_en", {7'd0, en}, 8'd1);
        step();
        last = 8'h08;
        step();
        chk("t2_rel_en", {7'd0, en}, 8'd0);
        req = 8'h18; last = 8'h00;
        step();
        chk("t2_ptr4", {5'd0, select}, 8'd4);
        last = 8'h10;
        step();
        req = 8'h00; last = 8'h00;
        step();

        // full rotation from ptr 0
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        req = 8'hFF; last = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("t3_sel", {5'd0, select}, 8'(i % 8));
            chk("t3_en_busy", {7'd0, en}, 8'd1);
            step();
            chk("t3_en_idle", {7'd0, en}, 8'd0);
        end
        req = 8'h00; last = 8'h00;
        step();

        // backpressure on last beat (ptr is 1)
        req = 8'h44; last = 8'h04; out_ready = 1'b0;
        step();
        chk("t4_grant", grant, 8'h04);
        repeat (5) begin
            step();
            chk("t4_hold", grant, 8'h04);
        end
        out_ready = 1'b1;
        step();
        chk("t4_rel", grant, 8'h00);
        last = 8'h00;
        step();
        chk("t4_next", grant, 8'h40);
        last = 8'h40;
        step();
        req = 8'h00; last = 8'h00;
        step();

        // asynchronous reset mid-packet (ptr is 7)
        req = 8'h20;
        step();
        chk("t5_grant", grant, 8'h20);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_async_grant", grant, 8'h00);
        chk("t5_async_en", {7'd0, en}, 8'd0);
        step();
        rst_n = 1'b1;
        req = 8'h21;
        step();
        chk("t5_ptr0", grant, 8'h01);
        last = 8'h01;
        step();
        req = 8'h00; last = 8'h00;
        step();

        // owner starves (ptr is 1)
        req = 8'h20;
        step();
        chk("t6_grant", grant, 8'h20);
        req = 8'h00;
        repeat (15) step();
        chk("t6_pre_en", {7'd0, en}, 8'd1);
`ifdef MUX_ARB_TIMEOUT_EN
        step();
        chk("t6_timeout", {7'd0, timeout}, 8'd1);
        chk("t6_to_en", {7'd0, en}, 8'd0);
        step();
        chk("t6_to_pulse", {7'd0, timeout}, 8'd0);
`else
        repeat (4) step();
        chk("t6_hold", grant, 8'h20);
        chk("t6_no_to", {7'd0, timeout}, 8'd0);
        req = 8'h20; last = 8'h20;
        step();
        req = 8'h00; last = 8'h00;
        step();
`endif
        req = 8'h41;
        step();
        chk("t6_ptr6", grant, 8'h40);
        last = 8'h40;
        step();
        req = 8'h00; last = 8'h00;
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
